sc_coin_reg_backg_bank: RTL
===========================

SC_COIN_REG_BACKG_BANK -- requirements
Module: sc_coin_reg_backg_bank

Interface
REQ-001 Parameter DATAWIDTH, default 8; pattern width in bits.
REQ-002 Parameter LEVELS, default 10; number of level-table entries.
REQ-003 Parameter SEL_WIDTH, default 4; selector width. LEVELS SHALL be <= 2**SEL_WIDTH.
REQ-004 Parameter LEVEL_TABLE, default {8'hFF,8'h00,8'h24,8'h00,8'h24,8'h00,8'h24,8'hFF,8'h81,8'h24}; flattened LEVELS*DATAWIDTH table, entry 0 in the LSBs.
REQ-005 Parameter INIT_PATTERN, default 0; losing/cleared pattern.
REQ-006 Parameter BLINK_DIV, default 1048576; clock cycles per blink half-period, >= 2.
REQ-007 Parameter BLINK_COUNT, default 3; number of full off/on blink cycles per sequence, >= 1.
REQ-008 SC_CoinRegBackgBank_CLOCK_50  in  1  sole clock; all state on rising edge.
REQ-009 SC_CoinRegBackgBank_RESET_InLow  in  1  asynchronous, active-low reset.
REQ-010 SC_CoinRegBackgBank_clear_InLow  in  1  load INIT_PATTERN, abort blink.
REQ-011 SC_CoinRegBackgBank_load_InLow  in  1  load selected table entry, abort blink.
REQ-012 SC_CoinRegBackgBank_coin_InLow  in  1  coin event; blanks a non-initial pattern.
REQ-013 SC_CoinRegBackgBank_blinkstart_In  in  1  request one blink sequence.
REQ-014 SC_CoinRegBackgBank_transitioncounter_InBUS  in  SEL_WIDTH  level-table selector.
REQ-015 SC_CoinRegBackgBank_data_OutBUS  out  DATAWIDTH  registered pattern.
REQ-016 SC_CoinRegBackgBank_blinking_Out  out  1  high while the FSM is not in HOLD.
REQ-017 SC_CoinRegBackgBank_done_Out  out  1  one-cycle pulse when a blink sequence completes normally.

Function
REQ-018 Level lookup is combinational: LEVEL = LEVEL_TABLE entry[sel] when sel < LEVELS, else all zeros.
REQ-019 FSM states: HOLD, BLANK, SHOW. Outputs are registered; every accepted event takes effect on data_OutBUS one cycle after the sampling edge.
REQ-020 Priority per cycle: clear > load > coin > blinkstart > timer.
REQ-021 clear low: register <= INIT_PATTERN; FSM <= HOLD; timer and cycle counter <= 0; no done pulse.
REQ-022 load low (clear high): register <= LEVEL; FSM <= HOLD; counters <= 0; no done pulse.
REQ-023 coin low (clear and load high) with register != INIT_PATTERN: register <= 0; FSM <= HOLD; counters <= 0. With register == INIT_PATTERN, coin has no effect.
REQ-024 blinkstart high in HOLD with no higher-priority event: FSM <= BLANK, register <= 0, timer <= 0. blinkstart outside HOLD is ignored.
REQ-025 Timer counts 0..BLINK_DIV-1 in BLANK and SHOW, wraps to 0, and asserts terminal count (tc) at BLINK_DIV-1.
REQ-026 BLANK with tc: FSM <= SHOW; register <= LEVEL, re-sampled at that edge.
REQ-027 SHOW with tc: cycle counter increments. If the new count < BLINK_COUNT, FSM <= BLANK and register <= 0.
REQ-028 SHOW with tc and the new count == BLINK_COUNT: FSM <= HOLD; register <= LEVEL; done_Out = 1 for exactly one cycle; cycle counter <= 0.
REQ-029 HOLD with no event: register holds its value.
REQ-030 The cycle counter width is $clog2(BLINK_COUNT+1) and the timer width is $clog2(BLINK_DIV); neither counter overflows.
REQ-031 If a selector change occurs mid-sequence, the new LEVEL is used at the next SHOW entry.

Reset
REQ-032 RESET_InLow low SHALL immediately force: data_OutBUS = 0, FSM = HOLD, timer = 0, cycle counter = 0, done_Out = 0, blinking_Out = 0. This applies in any state, including mid-sequence.
REQ-033 After reset release, the first edge processes inputs normally; a pending blinkstart at that edge is accepted.

Structure
REQ-034 Package sc_coin_reg_backg_pkg SHALL hold the FSM state enum (HOLD/BLANK/SHOW) and the default LEVEL_TABLE constant.
REQ-035 Sub-module sc_blink_timer (parameter DIV; inputs clock, reset, clear, enable; output tc) SHALL implement the half-period prescaler.
REQ-036 The target RTL size is 120-400 lines.

Verification (BLINK_DIV=4, BLINK_COUNT=2, defaults otherwise)
REQ-037 Reset held low, then released -> data_OutBUS=0x00, blinking_Out=0; load_InLow=0 with sel=1 -> 0x81 next cycle.
REQ-038 sel=0, load, then blinkstart for 1 cycle -> 0x00 for 4 cycles, 0x24 for 4, 0x00 for 4, 0x24 thereafter; done_Out pulses once, coincident with the final transition to HOLD; blinking_Out is high for 16 cycles.
REQ-039 Register=0x81, coin_InLow=0 -> 0x00; register=INIT (0x00) after clear, coin -> stays 0x00 with no state change.
REQ-040 clear and load asserted in the same cycle -> INIT_PATTERN wins. load during BLANK -> LEVEL loaded, FSM HOLD, no done pulse.
REQ-041 sel=12 (>= LEVELS) with load -> 0x00. A second blinkstart mid-sequence -> ignored, total sequence still 16 cycles.
REQ-042 Reset asserted in SHOW, cycle 2 -> outputs are 0 immediately (asynchronously); after release, a new blinkstart starts a full sequence.

Source files
------------

// File: rtl/sc_coin_reg_backg_pkg.sv
// Shared FSM state type and default level table for the coin-register background bank.
// Table entry 0 sits in the least-significant byte.
package sc_coin_reg_backg_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } blinkState_t;

  localparam logic [79:0] DEFAULT_LEVEL_TABLE =
    {8'hFF, 8'h00, 8'h24, 8'h00, 8'h24, 8'h00, 8'h24, 8'hFF, 8'h81, 8'h24};

endpackage

// File: rtl/sc_blink_timer.sv
// Half-period prescaler: free-runs 0..DIV-1 while enabled; tc marks the last count.
// tc is combinational from the count register; clear is synchronous and wins over enable.
module sc_blink_timer #(
  parameter int DIV = 1048576
) (
  input  logic SC_BlinkTimer_CLOCK_50,
  input  logic SC_BlinkTimer_RESET_InLow,
  input  logic SC_BlinkTimer_clear_In,
  input  logic SC_BlinkTimer_enable_In,
  output logic SC_BlinkTimer_tc_Out
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] countQ;

  assign SC_BlinkTimer_tc_Out = SC_BlinkTimer_enable_In && (countQ == LAST);

  always_ff @(posedge SC_BlinkTimer_CLOCK_50 or negedge SC_BlinkTimer_RESET_InLow) begin
    if (!SC_BlinkTimer_RESET_InLow) begin
      countQ <= '0;
    end else if (SC_BlinkTimer_clear_In) begin
      countQ <= '0;
    end else if (SC_BlinkTimer_enable_In) begin
      countQ <= SC_BlinkTimer_tc_Out ? '0 : countQ + 1'b1;
    end
  end

endmodule

// File: rtl/sc_coin_reg_backg_bank.sv
// Background pattern register with clear/load/coin events and a timed blank/show blink sequence.
// Every accepted event reaches data_OutBUS one cycle after its sampling edge; no backpressure.
module sc_coin_reg_backg_bank
  import sc_coin_reg_backg_pkg::*;
#(
  parameter int DATAWIDTH  = 8,
  parameter int LEVELS     = 10,
  parameter int SEL_WIDTH  = 4,
  parameter logic [LEVELS*DATAWIDTH-1:0] LEVEL_TABLE = DEFAULT_LEVEL_TABLE,
  parameter logic [DATAWIDTH-1:0] INIT_PATTERN = '0,
  parameter int BLINK_DIV   = 1048576,
  parameter int BLINK_COUNT = 3
) (
  input  logic                 SC_CoinRegBackgBank_CLOCK_50,
  input  logic                 SC_CoinRegBackgBank_RESET_InLow,
  input  logic                 SC_CoinRegBackgBank_clear_InLow,
  input  logic                 SC_CoinRegBackgBank_load_InLow,
  input  logic                 SC_CoinRegBackgBank_coin_InLow,
  input  logic                 SC_CoinRegBackgBank_blinkstart_In,
  input  logic [SEL_WIDTH-1:0] SC_CoinRegBackgBank_transitioncounter_InBUS,
  output logic [DATAWIDTH-1:0] SC_CoinRegBackgBank_data_OutBUS,
  output logic                 SC_CoinRegBackgBank_blinking_Out,
  output logic                 SC_CoinRegBackgBank_done_Out
);

  localparam int CNT_W = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_COUNT);

  blinkState_t          stateQ, stateD;
  logic [DATAWIDTH-1:0] dataQ, dataD;
  logic [CNT_W-1:0]     cycleCntQ, cycleCntD, cycleNext;
  logic                 doneQ, doneD;
  logic                 timerClear, timerTc, timerEnable;
  logic [DATAWIDTH-1:0] levelPattern;

  // Selectors past the populated table read as all zeros.
  always_comb begin
    levelPattern = '0;
    for (int i = 0; i < LEVELS; i++) begin
      if (SC_CoinRegBackgBank_transitioncounter_InBUS == SEL_WIDTH'(i)) begin
        levelPattern = LEVEL_TABLE[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  assign timerEnable = (stateQ != HOLD);
  assign cycleNext   = cycleCntQ + 1'b1;

  sc_blink_timer #(
    .DIV(BLINK_DIV)
  ) uBlinkTimer (
    .SC_BlinkTimer_CLOCK_50   (SC_CoinRegBackgBank_CLOCK_50),
    .SC_BlinkTimer_RESET_InLow(SC_CoinRegBackgBank_RESET_InLow),
    .SC_BlinkTimer_clear_In   (timerClear),
    .SC_BlinkTimer_enable_In  (timerEnable),
    .SC_BlinkTimer_tc_Out     (timerTc)
  );

  always_comb begin
    stateD     = stateQ;
    dataD      = dataQ;
    cycleCntD  = cycleCntQ;
    doneD      = 1'b0;
    timerClear = 1'b0;
    if (!SC_CoinRegBackgBank_clear_InLow) begin
      stateD     = HOLD;
      dataD      = INIT_PATTERN;
      cycleCntD  = '0;
      timerClear = 1'b1;
    end else if (!SC_CoinRegBackgBank_load_InLow) begin
      stateD     = HOLD;
      dataD      = levelPattern;
      cycleCntD  = '0;
      timerClear = 1'b1;
    end else if (!SC_CoinRegBackgBank_coin_InLow && (dataQ != INIT_PATTERN)) begin
      stateD     = HOLD;
      dataD      = '0;
      cycleCntD  = '0;
      timerClear = 1'b1;
    end else if (SC_CoinRegBackgBank_blinkstart_In && (stateQ == HOLD)) begin
      stateD     = BLANK;
      dataD      = '0;
      timerClear = 1'b1;
    end else if (timerTc) begin
      case (stateQ)
        BLANK: begin
          stateD = SHOW;
          dataD  = levelPattern;
        end
        SHOW: begin
          if (cycleNext < CNT_LAST) begin
            stateD    = BLANK;
            dataD     = '0;
            cycleCntD = cycleNext;
          end else begin
            stateD    = HOLD;
            dataD     = levelPattern;
            cycleCntD = '0;
            doneD     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge SC_CoinRegBackgBank_CLOCK_50 or negedge SC_CoinRegBackgBank_RESET_InLow) begin
    if (!SC_CoinRegBackgBank_RESET_InLow) begin
      stateQ    <= HOLD;
      dataQ     <= '0;
      cycleCntQ <= '0;
      doneQ     <= 1'b0;
    end else begin
      stateQ    <= stateD;
      dataQ     <= dataD;
      cycleCntQ <= cycleCntD;
      doneQ     <= doneD;
    end
  end

  assign SC_CoinRegBackgBank_data_OutBUS  = dataQ;
  assign SC_CoinRegBackgBank_blinking_Out = (stateQ != HOLD);
  assign SC_CoinRegBackgBank_done_Out     = doneQ;

endmodule
